// File: rtl/enigma_pkg.sv
// Shared Enigma code/ASCII definitions used by both the receive and transmit paths.
package enigma_pkg;

    // Codes at or above this value are not part of the 64-entry alphabet
    localparam logic [7:0] CODE_UNKNOWN = 8'h40;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_SPACE  = 8'h20;

    // UART serialiser FSM encoding, also visible on the debug state port
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Inverse of the receive-side table: 0-9, A-Z, a-z, '?', '!', else space
    function automatic logic [7:0] code_to_ascii(input logic [7:0] code);
        logic [7:0] ascii;
        if (code >= CODE_UNKNOWN) begin
            ascii = ASCII_SPACE;
        end else if (code == 8'h3F) begin
            ascii = 8'h21;
        end else if (code == 8'h3E) begin
            ascii = 8'h3F;
        end else if (code >= 8'h24) begin
            ascii = code + 8'h3D;
        end else if (code >= 8'h0A) begin
            ascii = code + 8'h37;
        end else begin
            ascii = code + 8'h30;
        end
        return ascii;
    endfunction

endpackage

// File: rtl/data_tx_if.sv
// Bus between the encryptor output register and the transmit block.
//
// Handshake: send is a start strobe sampled on posedge clk; it is accepted
// only while busy=0. busy rises on the accepting edge and stays high until
// the last stop bit ends; done pulses for exactly one cycle at that point,
// with busy already low. send while busy=1 is dropped, nothing is queued.
interface data_tx_if #(
    parameter int NUM_CHARS = 10
);
    logic [8*NUM_CHARS-1:0] idata;
    logic                   send;
    logic                   TX;
    logic                   busy;
    logic                   done;
    logic [1:0]             state;   // serialiser FSM state, debug only

    modport master (
        output idata, send,
        input  TX, busy, done, state
    );

    modport slave (
        input  idata, send,
        output TX, busy, done, state
    );
endinterface

// File: rtl/data_tx_uart_tx_byte.sv
// Byte-wide 8N1 UART serialiser with a registered TX line.
//
// Handshake: data is captured on a posedge where start=1 and ready=1.
// ready is high while idle and also on the final cycle of the stop bit,
// so a caller can chain frames with no idle gap between them.
import enigma_pkg::*;

module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       TX,
    output logic       ready,
    output logic [1:0] state
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

    logic [1:0]    state_q;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          tx_q;
    logic          baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign ready     = (state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_last);
    assign TX        = tx_q;
    assign state     = state_q;

    // Frame sequencer: start bit, 8 data bits LSB first, stop bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            tx_q     <= 1'b1;
        end else if (start && ready) begin
            state_q  <= ST_START;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            shreg    <= data;
            tx_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state_q  <= ST_DATA;
                        tx_q     <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state_q <= ST_STOP;
                            bit_cnt <= 3'd0;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx_q    <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                ST_STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state_q  <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                    tx_q <= 1'b1;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    baud_cnt <= '0;
                    tx_q     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/data_tx.sv
// Transmit path: turns a byte-packed Enigma code word into ASCII UART frames,
// first byte (MSB) first, optionally terminated with CR LF.
import enigma_pkg::*;

module data_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_CHARS    = 10,
    parameter int APPEND_CRLF  = 1
) (
    input  logic      clk,
    input  logic      rst,
    data_tx_if.slave  bus
);

    localparam int DW    = 8 * NUM_CHARS;
    localparam int TOTAL = NUM_CHARS + ((APPEND_CRLF != 0) ? 2 : 0);
    localparam int CW    = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);
    localparam logic [CW-1:0] CR_IDX   = CW'(NUM_CHARS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Holds the characters not yet handed to the serialiser, next one on top
    logic [DW-1:0] shreg;
    logic [CW-1:0] char_cnt;
    logic [CW-1:0] next_idx;
    logic          busy_q;
    logic          done_q;
    logic          accept;
    logic          frame_end;
    logic          last_char;
    logic          byte_start;
    logic          byte_ready;
    logic [7:0]    byte_data;
    logic [7:0]    next_ascii;
    logic          tx_line;
    logic [1:0]    fsm_state;

    assign accept     = bus.send && !busy_q;
    assign frame_end  = busy_q && byte_ready;
    assign last_char  = (char_cnt == LAST_IDX);
    assign next_idx   = char_cnt + CNT_ONE;
    assign byte_start = accept || (frame_end && !last_char);

    // Character that follows the one currently on the line
    always_comb begin
        next_ascii = ASCII_SPACE;
        if (next_idx < CR_IDX) begin
            next_ascii = code_to_ascii(shreg[DW-1 -: 8]);
        end else if (next_idx == CR_IDX) begin
            next_ascii = ASCII_CR;
        end else begin
            next_ascii = ASCII_LF;
        end
    end

    // The first character goes straight from idata so TX drops the next cycle
    always_comb begin
        byte_data = busy_q ? next_ascii : code_to_ascii(bus.idata[DW-1 -: 8]);
    end

    // Character sequencing, word capture and busy/done generation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            char_cnt <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                shreg    <= bus.idata << 8;
                char_cnt <= '0;
                busy_q   <= 1'b1;
            end else if (frame_end) begin
                if (last_char) begin
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    char_cnt <= '0;
                end else begin
                    char_cnt <= next_idx;
                    shreg    <= shreg << 8;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk   (clk),
        .rst   (rst),
        .data  (byte_data),
        .start (byte_start),
        .TX    (tx_line),
        .ready (byte_ready),
        .state (fsm_state)
    );

    assign bus.TX    = tx_line;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.state = fsm_state;

endmodule

// File: doc/data_tx.md
Name: data_tx

Overview:
- Transmit-side counterpart of the receive path that packs UART characters into 6-bit Enigma codes.
- Takes a 10-character, byte-packed code word from the cipher core and converts each code back to ASCII.
- Serialises the characters as 8N1 UART frames on TX, MSB byte first, optionally followed by CR LF.
- Sits between the encryptor output register and the board TX pin; owns its own bit-timing.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- NUM_CHARS, 10, bytes in idata; idata width = 8*NUM_CHARS.
- APPEND_CRLF, 1, when 1 send 0x0D then 0x0A after the last character.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- idata  in  8*NUM_CHARS  code word; byte [79:72] is the first character, [7:0] the last.
- send  in  1  start strobe, sampled on posedge while idle.
- TX  out  1  UART serial line; idles high.
- busy  out  1  high from the cycle after send is accepted until the last stop bit ends.
- done  out  1  single-cycle pulse when the last frame's stop bit completes.

Behaviour:
- Reset (rst=0, async): TX=1, busy=0, done=0, FSM=IDLE, all counters 0; applies immediately even mid-frame, aborting any frame in progress. No partial frame resumes after rst returns high.
- Code-to-ASCII map, applied per byte at load:
  - 0x00-0x09 -> 0x30-0x39
  - 0x0A-0x23 -> 0x41-0x5A
  - 0x24-0x3D -> 0x61-0x7A
  - 0x3E -> 0x3F ('?')
  - 0x3F -> 0x21 ('!')
  - any value >= 0x40 -> 0x20 (space)
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if send=1, latch idata into a shift register, char_cnt=0, go to START next cycle; busy rises the same edge.
  - START: TX=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits of the ASCII of the current byte, LSB first, each held CLKS_PER_BIT cycles.
  - STOP: TX=1 for CLKS_PER_BIT cycles. On the last stop cycle:
    - if more characters remain (NUM_CHARS, plus 2 when APPEND_CRLF), shift the next byte in, increment char_cnt, go directly to START (no idle gap);
    - otherwise go to IDLE, pulse done=1 for one cycle, busy=0 the same cycle.
- Latency: the first start bit appears on TX on the cycle after send is sampled. Each frame is exactly 10*CLKS_PER_BIT cycles. Total busy time is (NUM_CHARS + 2*APPEND_CRLF)*10*CLKS_PER_BIT cycles.
- send while busy=1 is ignored (no queueing). idata changes after acceptance have no effect.
- send held high continuously: a new transfer starts on the cycle after done, using the idata present at that edge.
- The baud counter is wide enough for CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. The bit counter runs 0..7.
- TX is driven from a register; it carries no combinational path from inputs.

Decomposition:
- Shared package enigma_pkg:
  - code/ASCII constants: CODE_UNKNOWN=0x40, ASCII_CR=0x0D, ASCII_LF=0x0A, ASCII_SPACE=0x20;
  - function code_to_ascii, the inverse of the receive-side table, so both directions share one definition.
- One sub-module, uart_tx_byte: byte-wide 8N1 serialiser with inputs (clk, rst, data[7:0], start) and outputs (TX, ready), parameterised by CLKS_PER_BIT.
- data_tx keeps character sequencing, the shift register, CRLF insertion and busy/done.

Test Plan (bench uses CLKS_PER_BIT=4, so each frame is 40 cycles):
- Reset check: hold rst=0 -> TX=1, busy=0, done=0. Release rst with send=0 -> TX stays 1 for 100 cycles.
- "HELLOworld":
  - stimulus: idata=0x11_0E_15_15_18_3A_32_35_2F_27, pulse send;
  - decoded TX bytes must be 48 45 4C 4C 4F 77 6F 72 6C 64 0D 0A;
  - busy must stay high exactly 480 cycles, then one done pulse.
- Special/unknown codes: idata bytes 0x3E,0x3F,0x40,0xFF,0x00,0x09,0x0A,0x23,0x24,0x3D with APPEND_CRLF=0 -> TX bytes 3F 21 20 20 30 39 41 5A 61 7A, busy=400 cycles.
- Ignored send: pulse send again at cycle 100 of a transfer with different idata -> output stream unchanged, a single done.
- Reset mid-frame: assert rst during the DATA state of character 3 -> TX=1 in the same cycle, busy=0. A subsequent send restarts from character 0.
- Back-to-back: hold send=1 across two transfers -> the second start bit follows done by exactly 1 cycle, with no gap between frames inside a transfer.
